// File: rtl/instr_mem_loader.sv
// Packs a big-endian byte stream into 32-bit instruction words and writes them into instruction memory.
// Optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd3;
`endif
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic [2:0]        state;
  logic [1:0]        byte_cnt;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] cur_addr;
  logic [23:0]       shift_reg;
  logic [ADDR_W:0]   clamped;
  logic              err_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  always_comb begin
    clamped = (num_words > DEPTH_W) ? DEPTH_W : num_words;
  end

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign wr_en = (state == S_WRITE);
`ifdef LOADER_CHECKSUM_EN
  assign in_ready = (state == S_LOAD) || (state == S_CHECK);
  assign err      = err_q;
`else
  assign in_ready = (state == S_LOAD);
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      byte_cnt  <= 2'd0;
      remaining <= '0;
      cur_addr  <= '0;
      shift_reg <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      err_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= 8'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            byte_cnt  <= 2'd0;
            shift_reg <= '0;
            err_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
            if (num_words == '0) begin
              state <= S_DONE;
            end else begin
              cur_addr  <= base_addr;
              remaining <= clamped;
              state     <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          // Abort wins over a concurrent 4th byte so a partial load never writes.
          if (abort) begin
            state <= S_IDLE;
          end else if (in_valid) begin
            shift_reg <= {shift_reg[15:0], in_byte};
            byte_cnt  <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum      <= csum ^ in_byte;
`endif
            if (byte_cnt == 2'd3) begin
              wr_data <= {shift_reg, in_byte};
              wr_addr <= cur_addr;
              state   <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            cur_addr  <= cur_addr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
            if (remaining == (ADDR_W+1)'(1)) begin
`ifdef LOADER_CHECKSUM_EN
              state <= S_CHECK;
`else
              state <= S_DONE;
`endif
            end else begin
              state <= S_LOAD;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (in_valid) begin
            if (in_byte != csum) err_q <= 1'b1;
            state <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader; expected writes come from an address/word list model.
module tb_instr_mem_loader;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_byte = 8'd0;
  logic          in_ready, wr_en, busy, done, err;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [AW-1:0] mon_addr[$];
  logic [31:0]   mon_data[$];
  int            mon_cyc[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  bit            ready_viol = 1'b0;
  logic [7:0]    bq[$];
  logic [31:0]   words[$];
  int            start_cyc = 0;

  instr_mem_loader #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .abort(abort), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        mon_addr.push_back(wr_addr);
        mon_data.push_back(wr_data);
        mon_cyc.push_back(cyc);
        if (in_ready) ready_viol = 1'b1;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    mon_addr.delete(); mon_data.delete(); mon_cyc.delete();
    done_cnt = 0; ready_viol = 1'b0;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n);
    start = 1'b1; base_addr = b; num_words = n; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Byte stream for the current word list, MSB first, plus checksum byte when enabled.
  task automatic build_bytes();
    bq.delete();
    foreach (words[i]) for (int s = 3; s >= 0; s--) bq.push_back(8'(words[i] >> (8 * s)));
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'd0;
      foreach (bq[i]) x = x ^ bq[i];
      bq.push_back(x);
    end
`endif
  endtask

  // pat: 0 continuous, 1 toggling, 2 random valid
  task automatic feed(input int pat, input int limit, output bit ok);
    int idx;
    int c;
    bit acc;
    idx = 0; c = 0;
    while (idx < bq.size() && c < limit) begin
      in_valid = (pat == 0) ? 1'b1 : (pat == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
      in_byte = in_valid ? bq[idx] : 8'($urandom);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      c++;
    end
    in_valid = 1'b0;
    ok = (idx == bq.size());
  endtask

  task automatic wait_done(input int limit, output bit ok);
    int c;
    c = 0;
    while (done_cnt == 0 && c < limit) begin
      @(posedge clk);
      c++;
    end
    #1;
    ok = (done_cnt != 0);
  endtask

  task automatic test_reset();
    bit ok;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, wr_en, busy, done, err} !== 5'b0 || wr_addr !== '0 || wr_data !== '0) begin
      errors++;
      $display("FAIL reset_initial: flags=%b addr=%h data=%h want all 0", {in_ready, wr_en, busy, done, err}, wr_addr, wr_data);
    end
    rst = 1'b0;
    clear_mon();
    words = '{32'hDEADBEEF, 32'h12345678};
    build_bytes();
    while (bq.size() > 5) void'(bq.pop_back());
    do_start(5'd7, 6'd2);
    feed(0, 40, ok);
    checks++;
    if (!ok || mon_data.size() != 1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_preload: ok=%0d writes=%0d busy=%b want ok=1 writes=1 busy=1", ok, mon_data.size(), busy);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, wr_en, busy, done, err} !== 5'b0 || wr_addr !== '0 || wr_data !== '0) begin
      errors++;
      $display("FAIL reset_async: flags=%b addr=%h data=%h want all 0", {in_ready, wr_en, busy, done, err}, wr_addr, wr_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok1, ok2;
    clear_mon();
    words = '{32'h8C430003};
    build_bytes();
    do_start(5'd0, 6'd1);
    feed(0, 40, ok1);
    wait_done(20, ok2);
    checks++;
    if (!(ok1 && ok2)) begin
      errors++;
      $display("FAIL single_timeout: feed=%0d done=%0d want 1 1", ok1, ok2);
    end
    checks++;
    if (mon_data.size() != 1) begin
      errors++;
      $display("FAIL single_count: got %0d writes want 1", mon_data.size());
    end else if (mon_addr[0] !== 5'd0 || mon_data[0] !== 32'h8C430003) begin
      errors++;
      $display("FAIL single_word: got %h@%0d want 8c430003@0", mon_data[0], mon_addr[0]);
    end
`ifndef LOADER_CHECKSUM_EN
    checks++;
    if (mon_cyc.size() != 1 || done_cyc != mon_cyc[0] + 1) begin
      errors++;
      $display("FAIL single_done_lat: done at %0d, write at %0d, want write+1", done_cyc, (mon_cyc.size() > 0) ? mon_cyc[0] : -1);
    end
`endif
    checks++;
    if (ready_viol || done_cnt != 1) begin
      errors++;
      $display("FAIL single_ready_done: ready_in_write=%0d done_pulses=%0d want 0 1", ready_viol, done_cnt);
    end
  endtask

  task automatic test_wrap();
    bit ok1, ok2;
    clear_mon();
    words = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    build_bytes();
    do_start(5'd30, 6'd3);
    feed(1, 100, ok1);
    wait_done(20, ok2);
    checks++;
    if (!(ok1 && ok2) || mon_data.size() != 3) begin
      errors++;
      $display("FAIL wrap_count: feed=%0d done=%0d writes=%0d want 1 1 3", ok1, ok2, mon_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (mon_addr[i] !== AW'((30 + i) % DEPTH) || mon_data[i] !== words[i]) begin
          errors++;
          $display("FAIL wrap_word%0d: got %h@%0d want %h@%0d", i, mon_data[i], mon_addr[i], words[i], (30 + i) % DEPTH);
        end
      end
    end
  endtask

  task automatic test_clamp_zero();
    bit ok1, ok2;
    logic [AW-1:0] b;
    clear_mon();
    do_start(AW'($urandom), 6'd0);
    wait_done(5, ok1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!ok1 || done_cyc != start_cyc + 1 || mon_data.size() != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL zero_len: done=%0d at %0d (start %0d) writes=%0d pulses=%0d want done start+1, 0 writes, 1 pulse",
               ok1, done_cyc, start_cyc, mon_data.size(), done_cnt);
    end
    clear_mon();
    words.delete();
    for (int i = 0; i < 32; i++) words.push_back($urandom);
    build_bytes();
    b = AW'($urandom);
    do_start(b, 6'd40);
    feed(0, 400, ok1);
    wait_done(20, ok2);
    checks++;
    if (!(ok1 && ok2) || mon_data.size() != 32 || done_cnt != 1) begin
      errors++;
      $display("FAIL clamp_count: feed=%0d done=%0d writes=%0d pulses=%0d want 1 1 32 1", ok1, ok2, mon_data.size(), done_cnt);
    end else begin
      int bad;
      bad = 0;
      for (int i = 0; i < 32; i++)
        if (mon_addr[i] !== AW'((int'(b) + i) % DEPTH) || mon_data[i] !== words[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL clamp_words: got %0d wrong words want 0", bad);
      end
    end
  endtask

  task automatic test_random();
    bit ok1, ok2;
    logic [AW-1:0] b;
    int n, pat;
    for (int it = 0; it < 6; it++) begin
      clear_mon();
      n = $urandom_range(1, 6);
      pat = $urandom_range(0, 2);
      b = AW'($urandom);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      build_bytes();
      do_start(b, (AW+1)'(n));
      feed(pat, 400, ok1);
      wait_done(20, ok2);
      checks++;
      if (!(ok1 && ok2) || mon_data.size() != n) begin
        errors++;
        $display("FAIL rand%0d_count: feed=%0d done=%0d writes=%0d want 1 1 %0d", it, ok1, ok2, mon_data.size(), n);
      end else begin
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++)
          if (mon_addr[i] !== AW'((int'(b) + i) % DEPTH) || mon_data[i] !== words[i]) bad++;
`ifndef LOADER_CHECKSUM_EN
        if (done_cyc != mon_cyc[n-1] + 1) bad++;
`endif
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL rand%0d_words: %0d wrong words/timing want 0 (base %0d n %0d pat %0d)", it, bad, b, n, pat);
        end
      end
    end
  endtask

  task automatic test_abort();
    bit ok1;
    logic [AW-1:0] b;
    clear_mon();
    b = AW'($urandom);
    words = '{32'hA1B2C3D4, 32'hE5F60718};
    build_bytes();
    while (bq.size() > 6) void'(bq.pop_back());
    do_start(b, 6'd2);
    feed(2, 200, ok1);
    do_start(5'd3, 6'd0);
    checks++;
    if (!ok1 || busy !== 1'b1 || done_cnt != 0) begin
      errors++;
      $display("FAIL abort_busy_start: feed=%0d busy=%b pulses=%0d want 1 1 0", ok1, busy, done_cnt);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b want 0", busy);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (mon_data.size() != 1 || done_cnt != 0) begin
      errors++;
      $display("FAIL abort_writes: writes=%0d pulses=%0d want 1 0", mon_data.size(), done_cnt);
    end else if (mon_addr[0] !== b || mon_data[0] !== 32'hA1B2C3D4) begin
      errors++;
      $display("FAIL abort_word1: got %h@%0d want a1b2c3d4@%0d", mon_data[0], mon_addr[0], b);
    end
    clear_mon();
    words = '{32'h0F1E2D3C};
    build_bytes();
    while (bq.size() > 3) void'(bq.pop_back());
    do_start(5'd9, 6'd1);
    feed(0, 20, ok1);
    in_valid = 1'b1; in_byte = 8'h3C; abort = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_prio_ready: in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (mon_data.size() != 0 || done_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_prio: writes=%0d pulses=%0d busy=%b want 0 0 0", mon_data.size(), done_cnt, busy);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit ok1, ok2;
    clear_mon();
    words = '{32'h8C430003};
    build_bytes();
    do_start(5'd4, 6'd1);
    feed(0, 40, ok1);
    wait_done(20, ok2);
    checks++;
    if (!(ok1 && ok2) || err !== 1'b0 || bq[4] !== 8'hCC) begin
      errors++;
      $display("FAIL csum_good: feed=%0d done=%0d err=%b want 1 1 0", ok1, ok2, err);
    end
    clear_mon();
    build_bytes();
    bq[4] = bq[4] ^ 8'h01;
    do_start(5'd4, 6'd1);
    feed(0, 40, ok1);
    wait_done(20, ok2);
    checks++;
    if (!(ok1 && ok2) || err !== 1'b1 || mon_data.size() != 1) begin
      errors++;
      $display("FAIL csum_bad: feed=%0d done=%0d err=%b writes=%0d want 1 1 1 1", ok1, ok2, err, mon_data.size());
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL csum_hold: err=%b want 1", err);
    end
    do_start(5'd0, 6'd0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL csum_clear: err=%b want 0", err);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_clamp_zero();
    test_random();
    test_abort();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
